// File: rtl/fetch_decode_register_pkg.sv
// GENERAL_DEFS: shared definitions for the fetch/decode pipeline register.
//   WORD                 - address width
//   flush_pipeline_sig   - flush request encoding (FLUSH_PIPELINE kills in-flight work)
//   fd_state_e           - pairing FSM states (EXPECT_FIRST, HAVE_PREFIX)
//   PREFIX_111xx         - halfword[15:11] patterns that open a 32-bit Thumb instruction
package GENERAL_DEFS;

    localparam int unsigned WORD = 32;

    typedef enum logic {
        NO_FLUSH       = 1'b0,
        FLUSH_PIPELINE = 1'b1
    } flush_pipeline_sig;

    typedef enum logic {
        EXPECT_FIRST = 1'b0,
        HAVE_PREFIX  = 1'b1
    } fd_state_e;

    localparam logic [4:0] PREFIX_11101 = 5'b11101;
    localparam logic [4:0] PREFIX_11110 = 5'b11110;
    localparam logic [4:0] PREFIX_11111 = 5'b11111;

endpackage

// File: rtl/fetch_decode_register_if.sv
// fetch_decode_register_if: fetch-to-decode bundle.
//   Inputs to the register : instr_hw_i, program_counter_i, is_valid_i,
//                            stall_i, flush_pipeline_i
//   Outputs to decode      : instr_hw1_o, instr_hw2_o, is_32bit_o,
//                            program_counter_o, is_valid_o
//   master - fetch/hazard side (drives the inputs, observes the outputs)
//   slave  - the pipeline register itself
interface fetch_decode_register_if;
    import GENERAL_DEFS::*;

    logic [15:0]       instr_hw_i;
    logic [WORD-1:0]   program_counter_i;
    logic              is_valid_i;
    logic              stall_i;
    flush_pipeline_sig flush_pipeline_i;

    logic [15:0]       instr_hw1_o;
    logic [15:0]       instr_hw2_o;
    logic              is_32bit_o;
    logic [WORD-1:0]   program_counter_o;
    logic              is_valid_o;

    modport master (
        output instr_hw_i, program_counter_i, is_valid_i, stall_i, flush_pipeline_i,
        input  instr_hw1_o, instr_hw2_o, is_32bit_o, program_counter_o, is_valid_o
    );

    modport slave (
        input  instr_hw_i, program_counter_i, is_valid_i, stall_i, flush_pipeline_i,
        output instr_hw1_o, instr_hw2_o, is_32bit_o, program_counter_o, is_valid_o
    );

endinterface

// File: rtl/fetch_decode_register_prefix_detect.sv
// thumb32_prefix_detect: combinational classifier, flags a halfword whose
// bits[15:11] mark it as the first half of a 32-bit Thumb instruction.
//   hw        - halfword under test
//   is_prefix - 1 when hw[15:11] is 11101, 11110 or 11111
// Only needed when 32-bit pairing is built in (macro THUMB32_PAIR_EN).
`ifdef THUMB32_PAIR_EN
module thumb32_prefix_detect
    import GENERAL_DEFS::*;
(
    input  logic [15:0] hw,
    output logic        is_prefix
);

    always_comb begin
        is_prefix = 1'b0;
        case (hw[15:11])
            PREFIX_11101,
            PREFIX_11110,
            PREFIX_11111: is_prefix = 1'b1;
            default:      is_prefix = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/fetch_decode_register.sv
// fetch_decode_register: IF/ID pipeline register that reassembles 32-bit
// Thumb instructions from two consecutive fetched halfwords.
//   clk_i      - clock, all state on rising edge
//   reset_n_i  - synchronous active-low reset (beats flush and stall)
//   bus        - fetch_decode_register_if.slave (fetch inputs, stall, flush,
//                decode-side outputs)
// Macro THUMB32_PAIR_EN: when defined, prefix halfwords are held and merged
// with the following halfword; when undefined every valid halfword passes
// straight through as a 16-bit instruction.
module fetch_decode_register
    import GENERAL_DEFS::*;
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    fetch_decode_register_if.slave       bus
);

    fd_state_e       state, next_state;
    logic            valid_q, next_valid;
    logic [15:0]     hw1_q, next_hw1;
    logic [WORD-1:0] pc_q, next_pc;

`ifdef THUMB32_PAIR_EN
    logic [15:0]     hw2_q, next_hw2;
    logic            is32_q, next_is32;
    logic [15:0]     pfx_hw_q, next_pfx_hw;
    logic [WORD-1:0] pfx_pc_q, next_pfx_pc;
    logic            is_prefix;

    thumb32_prefix_detect u_prefix_detect (
        .hw        (bus.instr_hw_i),
        .is_prefix (is_prefix)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= EXPECT_FIRST;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            valid_q  <= 1'b0;
            hw1_q    <= '0;
            pc_q     <= '0;
`ifdef THUMB32_PAIR_EN
            hw2_q    <= '0;
            is32_q   <= 1'b0;
            pfx_hw_q <= '0;
            pfx_pc_q <= '0;
`endif
        end else begin
            valid_q  <= next_valid;
            hw1_q    <= next_hw1;
            pc_q     <= next_pc;
`ifdef THUMB32_PAIR_EN
            hw2_q    <= next_hw2;
            is32_q   <= next_is32;
            pfx_hw_q <= next_pfx_hw;
            pfx_pc_q <= next_pfx_pc;
`endif
        end
    end

    // Flush outranks stall; flush only touches valid and state, data outputs
    // keep their last values.
    always_comb begin
        next_state  = state;
        next_valid  = valid_q;
        next_hw1    = hw1_q;
        next_pc     = pc_q;
`ifdef THUMB32_PAIR_EN
        next_hw2    = hw2_q;
        next_is32   = is32_q;
        next_pfx_hw = pfx_hw_q;
        next_pfx_pc = pfx_pc_q;
`endif
        if (bus.flush_pipeline_i == FLUSH_PIPELINE) begin
            next_valid  = 1'b0;
            next_state  = EXPECT_FIRST;
`ifdef THUMB32_PAIR_EN
            next_pfx_hw = '0;
            next_pfx_pc = '0;
`endif
        end else if (!bus.stall_i) begin
            next_valid = 1'b0;
`ifdef THUMB32_PAIR_EN
            if (bus.is_valid_i) begin
                if (state == HAVE_PREFIX) begin
                    // Second halfword is taken as-is, never re-classified.
                    next_hw1   = pfx_hw_q;
                    next_hw2   = bus.instr_hw_i;
                    next_is32  = 1'b1;
                    next_pc    = pfx_pc_q;
                    next_valid = 1'b1;
                    next_state = EXPECT_FIRST;
                end else if (is_prefix) begin
                    next_pfx_hw = bus.instr_hw_i;
                    next_pfx_pc = bus.program_counter_i;
                    next_state  = HAVE_PREFIX;
                end else begin
                    next_hw1   = bus.instr_hw_i;
                    next_hw2   = '0;
                    next_is32  = 1'b0;
                    next_pc    = bus.program_counter_i;
                    next_valid = 1'b1;
                end
            end
`else
            if (bus.is_valid_i && state == EXPECT_FIRST) begin
                next_hw1   = bus.instr_hw_i;
                next_pc    = bus.program_counter_i;
                next_valid = 1'b1;
            end
`endif
        end
    end

    assign bus.instr_hw1_o       = hw1_q;
    assign bus.program_counter_o = pc_q;
    assign bus.is_valid_o        = valid_q;
`ifdef THUMB32_PAIR_EN
    assign bus.instr_hw2_o       = hw2_q;
    assign bus.is_32bit_o        = is32_q;
`else
    assign bus.instr_hw2_o       = '0;
    assign bus.is_32bit_o        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode_register.sv
// tb_fetch_decode_register: directed scenarios followed by random traffic,
// each cycle compared against a transaction-level reference model.
// Honours macro THUMB32_PAIR_EN the same way the design does.
module tb_fetch_decode_register;
    import GENERAL_DEFS::*;

`ifdef THUMB32_PAIR_EN
    localparam bit PAIR_EN = 1'b1;
`else
    localparam bit PAIR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;

    fetch_decode_register_if bus ();

    fetch_decode_register dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the decode-visible bundle plus an optional
    // pending first half.
    typedef struct {
        logic [15:0] hw;
        logic [31:0] pc;
    } half_t;

    logic [15:0] m_hw1, m_hw2;
    logic        m_is32, m_valid;
    logic [31:0] m_pc;
    half_t       pending[$];

    function automatic bit opens_pair(input logic [15:0] hw);
        int unsigned top;
        top = int'(hw) / 2048;
        return top >= 29;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit s, input bit f,
                              input logic [15:0] hw, input logic [31:0] pc);
        half_t h;
        if (!r) begin
            m_hw1 = 0; m_hw2 = 0; m_is32 = 0; m_valid = 0; m_pc = 0;
            pending.delete();
        end else if (f) begin
            m_valid = 0;
            pending.delete();
        end else if (s) begin
            // everything frozen
        end else if (!v) begin
            m_valid = 0;
        end else if (pending.size() != 0) begin
            h = pending.pop_front();
            m_hw1 = h.hw; m_hw2 = hw; m_is32 = 1; m_pc = h.pc; m_valid = 1;
        end else if (PAIR_EN && opens_pair(hw)) begin
            h.hw = hw; h.pc = pc;
            pending.push_back(h);
            m_valid = 0;
        end else begin
            m_hw1 = hw; m_hw2 = 0; m_is32 = 0; m_pc = pc; m_valid = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit v, input bit s,
                        input bit f, input logic [15:0] hw, input logic [31:0] pc);
        rst_n                 = r;
        bus.is_valid_i        = v;
        bus.stall_i           = s;
        bus.flush_pipeline_i  = f ? FLUSH_PIPELINE : NO_FLUSH;
        bus.instr_hw_i        = hw;
        bus.program_counter_i = pc;
        @(posedge clk);
        model_step(r, v, s, f, hw, pc);
        #1;
        check({tag, ".valid"}, 32'(bus.is_valid_o), 32'(m_valid));
        check({tag, ".hw1"},   32'(bus.instr_hw1_o), 32'(m_hw1));
        check({tag, ".hw2"},   32'(bus.instr_hw2_o), 32'(m_hw2));
        check({tag, ".is32"},  32'(bus.is_32bit_o), 32'(m_is32));
        check({tag, ".pc"},    bus.program_counter_o, m_pc);
    endtask

    initial begin
        logic [15:0] hw;
        logic [31:0] pc;
        bit r, v, s, f;
        n_checks = 0;
        n_fail   = 0;
        m_hw1 = 0; m_hw2 = 0; m_is32 = 0; m_valid = 0; m_pc = 0;

        // Reset state
        step("reset0", 0, 1, 0, 0, 16'hFFFF, 32'hDEAD);
        step("reset1", 0, 0, 1, 1, 16'hF000, 32'hBEEF);
        check("reset_valid", 32'(bus.is_valid_o), 32'h0);
        check("reset_pc", bus.program_counter_o, 32'h0);

        // Plain 16-bit instruction
        step("single", 1, 1, 0, 0, 16'h2005, 32'h100);
        check("single_hw1", 32'(bus.instr_hw1_o), 32'h2005);
        check("single_pc", bus.program_counter_o, 32'h100);
        check("single_valid", 32'(bus.is_valid_o), 32'h1);

        // Prefix followed by second half
        step("pair_a", 1, 1, 0, 0, 16'hF000, 32'h104);
        step("pair_b", 1, 1, 0, 0, 16'hF802, 32'h106);
`ifdef THUMB32_PAIR_EN
        check("pair_hw1", 32'(bus.instr_hw1_o), 32'hF000);
        check("pair_hw2", 32'(bus.instr_hw2_o), 32'hF802);
        check("pair_pc", bus.program_counter_o, 32'h104);
        check("pair_is32", 32'(bus.is_32bit_o), 32'h1);
`endif

        // Stall with junk while a prefix is held
        step("stall_a", 1, 1, 0, 0, 16'hF000, 32'h108);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1, 1, 1, 0, 16'(16'hE800 + i), 32'(32'h900 + i));
        step("stall_b", 1, 1, 0, 0, 16'hF802, 32'h10A);

        // Flush together with stall drops the prefix
        step("flush_a", 1, 1, 0, 0, 16'hF000, 32'h10C);
        step("flush_fs", 1, 1, 1, 1, 16'hE000, 32'h777);
        check("flush_valid", 32'(bus.is_valid_o), 32'h0);
        step("flush_b", 1, 1, 0, 0, 16'h2005, 32'h10E);
        check("flush_b_is32", 32'(bus.is_32bit_o), 32'h0);
        check("flush_b_hw1", 32'(bus.instr_hw1_o), 32'h2005);

        // Reset mid-pair
        step("rstmid_a", 1, 1, 0, 0, 16'hF000, 32'h110);
        step("rstmid_r", 0, 1, 1, 1, 16'hF802, 32'h112);
        check("rstmid_hw1", 32'(bus.instr_hw1_o), 32'h0);
        step("rstmid_b", 1, 1, 0, 0, 16'hF802, 32'h112);

        // Prefix pattern without pairing feature
        step("nopair", 1, 1, 0, 0, 16'hF000, 32'h114);
`ifndef THUMB32_PAIR_EN
        check("nopair_valid", 32'(bus.is_valid_o), 32'h1);
        check("nopair_hw1", 32'(bus.instr_hw1_o), 32'hF000);
        check("nopair_is32", 32'(bus.is_32bit_o), 32'h0);
`endif
        step("idle", 1, 0, 0, 0, 16'h1234, 32'h116);

        // Random traffic
        pc = 32'h200;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) != 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 11) == 0);
            hw = 16'($urandom);
            if ($urandom_range(0, 9) < 4)
                hw[15:11] = 5'(29 + $urandom_range(0, 2));
            step("rand", r, v, s, f, hw, pc);
            pc = pc + 32'd2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
